// File: rtl/exmem_arbiter_if.sv
// Bus bundle between the exmem arbiter, its two requesters (CPU, loader) and exmem.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface exmem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ack;
   logic [DW-1:0] cpu_rdata;

   logic          ldr_req;
   logic          ldr_we;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata;
   logic          ldr_ack;
   logic [DW-1:0] ldr_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wen;
   logic [DW-1:0] mem_q;

   logic          busy;
   logic          last_gnt;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  mem_q,
      output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
      output mem_addr, mem_data, mem_wen,
      output busy, last_gnt
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output mem_q,
      input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
      input  mem_addr, mem_data, mem_wen,
      input  busy, last_gnt
   );
endinterface

// File: rtl/exmem_arbiter.sv
// Two-requester (CPU / loader) arbiter and sequencer for the single-port exmem.
// One transaction at a time: IDLE -> ISSUE -> [WAIT x RD_LAT] -> ACK -> IDLE.
module exmem_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int RD_LAT       = 1,
   parameter int PRIORITY_CPU = 0
) (
   input  logic           clk,
   input  logic           reset,
   exmem_arbiter_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK   = 2'd3;

   localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

   logic [1:0]    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_gnt_q, last_gnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
   logic          gnt_ldr;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_gnt_d  = last_gnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;

      // On a tie, round-robin hands the grant to whoever did not have it last.
      if (bus.cpu_req && bus.ldr_req) begin
         gnt_ldr = (PRIORITY_CPU != 0) ? 1'b0 : ~last_gnt_q;
      end else begin
         gnt_ldr = bus.ldr_req;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req || bus.ldr_req) begin
               owner_d    = gnt_ldr;
               last_gnt_d = gnt_ldr;
               we_d       = gnt_ldr ? bus.ldr_we    : bus.cpu_we;
               addr_d     = gnt_ldr ? bus.ldr_addr  : bus.cpu_addr;
               wdata_d    = gnt_ldr ? bus.ldr_wdata : bus.cpu_wdata;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = we_q ? S_ACK : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == LAST_WAIT) begin
               cnt_d = '0;
               if (owner_q) begin
                  ldr_rdata_d = bus.mem_q;
               end else begin
                  cpu_rdata_d = bus.mem_q;
               end
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         last_gnt_q  <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_gnt_q  <= last_gnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   // Outputs decode from registered state only, so reset drops mem_wen/acks at once.
   assign bus.mem_addr  = addr_q;
   assign bus.mem_data  = wdata_q;
   assign bus.mem_wen   = (state_q == S_ISSUE) && we_q;
   assign bus.cpu_ack   = (state_q == S_ACK) && !owner_q;
   assign bus.ldr_ack   = (state_q == S_ACK) && owner_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.ldr_rdata = ldr_rdata_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.last_gnt  = last_gnt_q;

endmodule

// File: tb/tb_exmem_arbiter.sv
// Bench for exmem_arbiter: vector table, directed corner sequences and a randomized
// two-requester run checked against a transaction-level memory model.
module tb_exmem_arbiter;
   localparam int RD_LAT = 1;
   localparam int RD_TXN_LAT = 2 + RD_LAT;
   localparam int WR_TXN_LAT = 2;
   localparam int NRAND = 150;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   exmem_arbiter_if #(.AW(8), .DW(8)) b0 ();
   exmem_arbiter_if #(.AW(8), .DW(8)) b1 ();

   exmem_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT), .PRIORITY_CPU(0)) dut0 (
      .clk(clk), .reset(reset), .bus(b0.slave));
   exmem_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT), .PRIORITY_CPU(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1.slave));

   // exmem models: sync write, registered read, RD_LAT-deep q pipeline
   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];
   logic [7:0] q0 [RD_LAT];
   logic [7:0] q1 [RD_LAT];
   always @(posedge clk) begin
      if (b0.mem_wen) mem0[b0.mem_addr] <= b0.mem_data;
      if (b1.mem_wen) mem1[b1.mem_addr] <= b1.mem_data;
      q0[0] <= mem0[b0.mem_addr];
      q1[0] <= mem1[b1.mem_addr];
      for (int i = 1; i < RD_LAT; i++) begin
         q0[i] <= q0[i-1];
         q1[i] <= q1[i-1];
      end
   end
   assign b0.mem_q = q0[RD_LAT-1];
   assign b1.mem_q = q1[RD_LAT-1];

   int checks = 0;
   int errors = 0;

   logic [7:0] model_mem [256];
   bit         cur_we [2];
   logic [7:0] cur_addr [2];
   logic [7:0] cur_wd [2];
   bit         done [2];

   typedef struct {
      bit         who;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      int         exp_lat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_req(input bit who, input bit req, input bit we,
                            input logic [7:0] addr, input logic [7:0] wdata);
      if (who) begin
         b0.ldr_we = we; b0.ldr_addr = addr; b0.ldr_wdata = wdata; b0.ldr_req = req;
      end else begin
         b0.cpu_we = we; b0.cpu_addr = addr; b0.cpu_wdata = wdata; b0.cpu_req = req;
      end
   endtask

   // Single transaction on dut0, started at a negedge with the arbiter idle.
   task automatic txn(input bit who, input bit we, input logic [7:0] addr,
                      input logic [7:0] wdata, output logic [7:0] rdata,
                      output int lat, output int wens, output int other, output bit wen_ok);
      lat = -1; wens = 0; other = 0; wen_ok = 1'b1; rdata = '0;
      drive_req(who, 1'b1, we, addr, wdata);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (b0.mem_wen) begin
            wens++;
            if (b0.mem_addr != addr || b0.mem_data != wdata) wen_ok = 1'b0;
         end
         if (who ? b0.cpu_ack : b0.ldr_ack) other++;
         if (who ? b0.ldr_ack : b0.cpu_ack) begin
            lat = n;
            rdata = who ? b0.ldr_rdata : b0.cpu_rdata;
            break;
         end
      end
      drive_req(who, 1'b0, we, addr, wdata);
      @(negedge clk);
   endtask

   task automatic drv(input bit who, input int n);
      bit got;
      bit we;
      logic [7:0] addr;
      logic [7:0] wd;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(1, 3)) @(negedge clk);
         we   = 1'($urandom_range(0, 1));
         addr = 8'(8'h20 + $urandom_range(0, 7));
         wd   = 8'($urandom);
         cur_we[who] = we; cur_addr[who] = addr; cur_wd[who] = wd;
         drive_req(who, 1'b1, we, addr, wd);
         got = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = who ? b0.ldr_ack : b0.cpu_ack;
         end
         chk(who ? "rand_ldr_ack_seen" : "rand_cpu_ack_seen", int'(got), 1);
         drive_req(who, 1'b0, we, addr, wd);
      end
      done[who] = 1'b1;
   endtask

   task automatic monitor();
      int acks [2];
      bit prev_wen = 1'b0;
      bit wen_seen = 1'b0;
      logic [7:0] wa = '0;
      logic [7:0] wd = '0;
      int budget = 20000;
      acks[0] = 0; acks[1] = 0;
      while (!(done[0] && done[1]) && budget > 0) begin
         @(negedge clk);
         budget--;
         if (b0.mem_wen) begin
            chk("wen_single_cycle", int'(prev_wen), 0);
            wa = b0.mem_addr; wd = b0.mem_data; wen_seen = 1'b1;
         end
         prev_wen = b0.mem_wen;
         if (b0.cpu_ack || b0.ldr_ack) begin
            chk("ack_exclusive", int'(b0.cpu_ack && b0.ldr_ack), 0);
            for (int w = 0; w < 2; w++) begin
               if ((w == 1) ? b0.ldr_ack : b0.cpu_ack) begin
                  acks[w]++;
                  if (cur_we[w]) begin
                     chk("rand_wen_seen", int'(wen_seen), 1);
                     chk("rand_wen_addr", int'(wa), int'(cur_addr[w]));
                     chk("rand_wen_data", int'(wd), int'(cur_wd[w]));
                     model_mem[cur_addr[w]] = cur_wd[w];
                  end else begin
                     chk("rand_read_no_wen", int'(wen_seen), 0);
                     chk("rand_rdata", int'((w == 1) ? b0.ldr_rdata : b0.cpu_rdata),
                         int'(model_mem[cur_addr[w]]));
                  end
                  wen_seen = 1'b0;
               end
            end
         end
      end
      chk("rand_budget_left", int'(budget > 0), 1);
      chk("rand_cpu_ack_count", acks[0], NRAND);
      chk("rand_ldr_ack_count", acks[1], NRAND);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [10];
      logic [7:0] rd;
      int lat, wens, other;
      bit wok;
      int seq0 [4];
      int seq1 [4];
      int n0, n1, t, ldr_t, cpu_t, wen_t, nw, drain;

      b0.cpu_req = 0; b0.cpu_we = 0; b0.cpu_addr = '0; b0.cpu_wdata = '0;
      b0.ldr_req = 0; b0.ldr_we = 0; b0.ldr_addr = '0; b0.ldr_wdata = '0;
      b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
      b1.ldr_req = 0; b1.ldr_we = 0; b1.ldr_addr = '0; b1.ldr_wdata = '0;
      done[0] = 1'b0; done[1] = 1'b0;

      vecs[0] = '{0, 1, 8'hD4, 8'h14, 8'h00, WR_TXN_LAT};
      vecs[1] = '{0, 0, 8'hD4, 8'h00, 8'h14, RD_TXN_LAT};
      vecs[2] = '{1, 1, 8'h10, 8'h3C, 8'h00, WR_TXN_LAT};
      vecs[3] = '{0, 0, 8'h10, 8'h00, 8'h3C, RD_TXN_LAT};
      vecs[4] = '{1, 0, 8'hD4, 8'h00, 8'h14, RD_TXN_LAT};
      vecs[5] = '{0, 1, 8'h00, 8'hFF, 8'h00, WR_TXN_LAT};
      vecs[6] = '{1, 0, 8'h00, 8'h00, 8'hFF, RD_TXN_LAT};
      vecs[7] = '{1, 1, 8'hFF, 8'h01, 8'h00, WR_TXN_LAT};
      vecs[8] = '{0, 0, 8'hFF, 8'h00, 8'h01, RD_TXN_LAT};
      vecs[9] = '{0, 1, 8'hD4, 8'h14, 8'h00, WR_TXN_LAT};

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(b0.busy), 0);
      chk("rst_wen", int'(b0.mem_wen), 0);
      chk("rst_cpu_ack", int'(b0.cpu_ack), 0);
      chk("rst_ldr_ack", int'(b0.ldr_ack), 0);
      chk("rst_last_gnt", int'(b0.last_gnt), 1);
      chk("rst_mem_addr", int'(b0.mem_addr), 0);
      chk("rst_cpu_rdata", int'(b0.cpu_rdata), 0);
      reset = 1'b1;

      // T1: reset asserted while a write is in ISSUE
      drive_req(0, 1'b1, 1'b1, 8'h55, 8'hAA);
      @(negedge clk);
      chk("t1_issue_wen", int'(b0.mem_wen), 1);
      #1 reset = 1'b0;
      #1;
      chk("t1_wen_async", int'(b0.mem_wen), 0);
      chk("t1_busy", int'(b0.busy), 0);
      chk("t1_cpu_ack", int'(b0.cpu_ack), 0);
      chk("t1_mem_addr", int'(b0.mem_addr), 0);
      chk("t1_last_gnt", int'(b0.last_gnt), 1);
      drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // vector table (covers T2/T3)
      for (int i = 0; i < 10; i++) begin
         txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wens, other, wok);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_other_ack", i), other, 0);
         chk($sformatf("vec%0d_wen_count", i), wens, vecs[i].we ? 1 : 0);
         chk($sformatf("vec%0d_last_gnt", i), int'(b0.last_gnt), int'(vecs[i].who));
         if (vecs[i].we) chk($sformatf("vec%0d_wen_addr_data", i), int'(wok), 1);
         else chk($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp_rdata));
      end

      // T5: loader write granted first, CPU read of the same address queued behind it
      txn(0, 1'b1, 8'h10, 8'h00, rd, lat, wens, other, wok);
      drive_req(1, 1'b1, 1'b1, 8'h10, 8'h3C);
      @(negedge clk);
      drive_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
      ldr_t = -1; cpu_t = -1; wen_t = -1; nw = 0; rd = '0;
      for (int n = 1; n <= 40 && cpu_t < 0; n++) begin
         if (n > 1) @(negedge clk);
         if (b0.mem_wen) begin nw++; wen_t = n; end
         if (b0.ldr_ack) begin ldr_t = n; drive_req(1, 1'b0, 1'b1, 8'h10, 8'h3C); end
         if (b0.cpu_ack) begin cpu_t = n; rd = b0.cpu_rdata; drive_req(0, 1'b0, 1'b0, 8'h10, 8'h00); end
      end
      @(negedge clk);
      chk("t5_ldr_ack_time", ldr_t, WR_TXN_LAT);
      chk("t5_cpu_ack_time", cpu_t, WR_TXN_LAT + 1 + RD_TXN_LAT);
      chk("t5_rdata", int'(rd), 8'h3C);
      chk("t5_wen_count", nw, 1);
      chk("t5_wen_before_cpu_wait", int'(wen_t >= 0 && wen_t + RD_LAT + 1 < cpu_t), 1);

      // T6: reset during the WAIT of a CPU read
      drive_req(0, 1'b1, 1'b0, 8'hD4, 8'h00);
      repeat (2) @(negedge clk);
      chk("t6_in_wait_busy", int'(b0.busy), 1);
      chk("t6_rdata_before", int'(b0.cpu_rdata), 8'h3C);
      #1 reset = 1'b0;
      #1;
      chk("t6_cpu_ack", int'(b0.cpu_ack), 0);
      chk("t6_busy", int'(b0.busy), 0);
      chk("t6_rdata_cleared", int'(b0.cpu_rdata), 0);
      drive_req(0, 1'b0, 1'b0, 8'hD4, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      nw = 0;
      repeat (4) begin @(negedge clk); if (b0.cpu_ack) nw++; end
      chk("t6_no_late_ack", nw, 0);
      txn(0, 1'b0, 8'hD4, 8'h00, rd, lat, wens, other, wok);
      chk("t6_new_read_lat", lat, RD_TXN_LAT);
      chk("t6_new_read_rdata", int'(rd), 8'h14);

      // T4: both requesters held high on both priority variants
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      b0.cpu_we = 0; b0.cpu_addr = 8'hD4; b0.ldr_we = 0; b0.ldr_addr = 8'h10;
      b1.cpu_we = 0; b1.cpu_addr = 8'hD4; b1.ldr_we = 0; b1.ldr_addr = 8'h10;
      b0.cpu_req = 1; b0.ldr_req = 1; b1.cpu_req = 1; b1.ldr_req = 1;
      n0 = 0; n1 = 0;
      for (t = 0; t < 80 && (n0 < 4 || n1 < 4); t++) begin
         @(negedge clk);
         if ((b0.cpu_ack || b0.ldr_ack) && n0 < 4) begin
            seq0[n0] = int'(b0.ldr_ack);
            chk($sformatf("t4_rr_rdata%0d", n0), int'(b0.ldr_ack ? b0.ldr_rdata : b0.cpu_rdata),
                b0.ldr_ack ? 8'h3C : 8'h14);
            n0++;
         end
         if ((b1.cpu_ack || b1.ldr_ack) && n1 < 4) begin
            seq1[n1] = int'(b1.ldr_ack);
            n1++;
         end
      end
      b0.cpu_req = 0; b0.ldr_req = 0; b1.cpu_req = 0; b1.ldr_req = 0;
      chk("t4_rr_grants", n0, 4);
      chk("t4_pri_grants", n1, 4);
      for (int i = 0; i < 4; i++) begin
         if (i < n0) chk($sformatf("t4_rr_grant%0d", i), seq0[i], i % 2);
         if (i < n1) chk($sformatf("t4_pri_grant%0d", i), seq1[i], 0);
      end
      drain = 0;
      while ((b0.busy || b1.busy) && drain < 20) begin @(negedge clk); drain++; end
      chk("t4_drained", int'(b0.busy || b1.busy), 0);
      @(negedge clk);

      // randomized two-requester run over a pre-written address window
      for (int a = 0; a < 8; a++) begin
         txn(0, 1'b1, 8'(8'h20 + a), 8'(a * 17 + 3), rd, lat, wens, other, wok);
         chk($sformatf("prewrite%0d_lat", a), lat, WR_TXN_LAT);
         model_mem[8'(8'h20 + a)] = 8'(a * 17 + 3);
      end
      fork
         drv(0, NRAND);
         drv(1, NRAND);
         monitor();
      join
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
